// File: rtl/reg_stream_reader.sv
// Streams a contiguous (possibly wrapping) range of register-file entries out
// over a valid/ready interface, one word every two cycles at full rate.
module reg_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] CUR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] span;

  // Modular difference: a range with last below first wraps through the top.
  assign span = last_addr - first_addr;

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path
    // through the case below can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d       = first_addr;
          remaining_d = {1'b0, span} + REM_ONE;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        out_data_d  = rf_data;
        out_valid_d = 1'b1;
        out_last_d  = (remaining_q == REM_ONE);
        state_d     = SEND;
      end

      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = DONE;
          end else begin
            cur_d       = cur_q + CUR_ONE;
            remaining_d = remaining_q - REM_ONE;
            state_d     = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // All outputs come straight from registers; nothing is combinational from inputs.
  assign rf_addr   = cur_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_stream_reader.sv
// Self-checking bench for reg_stream_reader: directed ranges, randomized
// ranges and back-pressure, a mid-dump reset, all against a list-based model.
module tb_reg_stream_reader;

  localparam int NREG = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] first_addr;
  logic [2:0] last_addr;
  logic [2:0] rf_addr;
  logic [7:0] rf_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] regs [NREG];
  logic [7:0] rf_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file model; the mask lets the bench disturb read data mid-word.
  assign rf_data = regs[rf_addr] ^ rf_mask;

  reg_stream_reader #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_addr"}, rf_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One dump from f to l. Outputs are sampled on the falling edge and the
  // next-cycle inputs are driven right after, so an accept is decided here.
  task automatic run_dump(input logic [2:0] f, input logic [2:0] l,
                          input bit rnd, input int stall_first);
    int         n;
    logic [7:0] exp_data [$];
    logic [2:0] exp_addr [$];
    int         accepted = 0;
    int         cyc = 0;
    int         stall = 0;
    bit         done_seen = 0;
    bit         prev_v = 0;
    bit         prev_r = 0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    bit         r;

    n = ((int'(l) - int'(f) + NREG) % NREG) + 1;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(3'((int'(f) + i) % NREG));
      exp_data.push_back(regs[(int'(f) + i) % NREG]);
    end

    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b0; rf_mask = '0;
    @(negedge clk);
    start = 1'b0; first_addr = 3'($urandom); last_addr = 3'($urandom);
    cyc = 1;
    check("busy_after_start", busy, 1);
    check("valid_low_in_fetch", out_valid, 0);
    check("rf_addr_first", rf_addr, f);

    while (!done_seen && cyc < 400) begin
      if (cyc == 2) check("first_word_latency", out_valid, 1);
      if (!out_valid) check("last_qualified", out_last, 0);
      if (prev_v && !prev_r) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_d);
        check("stall_last", out_last, prev_l);
      end
      if (out_valid && accepted < n) check("rf_addr_seq", rf_addr, exp_addr[accepted]);

      if (done) begin
        check("words_before_done", accepted, n);
        if (!rnd && stall_first == 0) check("done_cycle", cyc, 2 * n + 1);
        done_seen = 1;
        start = 1'b0;
        rf_mask = '0;
      end else begin
        if (out_valid && accepted == 0 && stall < stall_first) begin
          r = 1'b0;
          stall++;
        end else begin
          r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        out_ready = r;
        rf_mask = (out_valid && !r) ? 8'($urandom_range(1, 255)) : 8'h00;
        start = ($urandom_range(0, 3) == 0);
        first_addr = 3'($urandom);
        last_addr = 3'($urandom);
        if (out_valid && r) begin
          if (accepted < n) begin
            check("word_data", out_data, exp_data[accepted]);
            check("word_last", out_last, (accepted == n - 1));
          end else begin
            check("extra_word", accepted, n - 1);
          end
          accepted++;
        end
        prev_v = out_valid;
        prev_r = r;
        prev_d = out_data;
        prev_l = out_last;
        @(negedge clk);
        cyc++;
      end
    end

    if (!done_seen) check("done_timeout", done_seen, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("valid_after_done", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
    out_ready = 1'b0; rf_mask = '0;
    for (int i = 0; i < NREG; i++) regs[i] = 8'(8'h10 + i);

    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; start = 1'b0;

    run_dump(3'd2, 3'd5, 1'b0, 0);
    run_dump(3'd6, 3'd1, 1'b0, 0);
    run_dump(3'd3, 3'd3, 1'b0, 0);
    run_dump(3'd4, 3'd3, 1'b0, 0);
    run_dump(3'd2, 3'd5, 1'b0, 5);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
      run_dump(3'($urandom), 3'($urandom), 1'b1, (k % 3 == 0) ? 3 : 0);
    end

    // Reset while the second word of a full dump is on offer.
    for (int i = 0; i < NREG; i++) regs[i] = 8'(8'h10 + i);
    @(negedge clk);
    start = 1'b1; first_addr = 3'd0; last_addr = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !(out_valid && rf_addr == 3'd1); i++) @(negedge clk);
    check("second_word_reached", (out_valid && rf_addr == 3'd1), 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_reset", done, 0);
      check("no_valid_after_reset", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
